perclos_scheduler: RTL and testbench
====================================

# perclos_scheduler

Frame-rate controller for the eye-closure (PERCLOS) measurement path. Once per video frame it samples the tracked eye height, first calibrates the open-eye reference height, then classifies each frame as open or closed. It keeps a sliding window of the last WIN_FRAMES valid frames and raises a fatigue alarm with hysteresis. It sits between the eye-tracking/LCD timing logic and the alarm/overlay display logic.

## Interface
- WIN_FRAMES, 64: sliding-window length in valid frames (power of two, 8..256).
- CAL_FRAMES, 16: valid frames used to establish the open-eye reference.
- ALARM_CNT, 26: closed-frame count at or above which the alarm sets.
- CLEAR_CNT, 16: closed-frame count at or below which the alarm clears (CLEAR_CNT < ALARM_CNT).
- module_clk  in  1  system clock; all logic on the rising edge.
- module_rst_n  in  1  asynchronous active-low reset.
- lcd_pixel_xpos  in  11  current LCD pixel column.
- lcd_pixel_ypos  in  11  current LCD pixel row.
- eye1_high  in  11  tracked eye height, in pixels.
- eye1_Wide  in  11  tracked eye width, in pixels; 0 means no eye found.
- recal  in  1  single-cycle pulse that restarts calibration.
- frame_tick  out  1  one-cycle pulse per frame.
- cal_done  out  1  high while in RUN.
- eye_ref  out  11  open-eye reference height.
- eye_closed  out  1  classification of the last valid frame (1 = closed).
- perclos_cnt  out  $clog2(WIN_FRAMES+1)  closed frames in the window.
- fatigue_alarm  out  1  fatigue flag.

## Operation
- Frame strobe: m = (xpos==1 && ypos==1). Register m as m_d. frame_tick = m & ~m_d, registered, so each frame produces exactly one tick regardless of how long m stays high.
- Sampling: on a tick cycle, eye1_high and eye1_Wide are captured. If eye1_Wide==0 the frame is invalid. An invalid frame does not advance any counter, the window or the classification; its only effect is the tick itself.
- States:
  - IDLE: entered from reset. Moves to CAL on the first tick; that tick is not sampled.
  - CAL: on each valid tick, eye_ref <= max(eye_ref, eye1_high) and cal_cnt increments. Moves to RUN after the CAL_FRAMES-th valid sample.
  - RUN: on each valid tick, closed = (eye1_high*5 < eye_ref), i.e. below 20 % of the reference, computed with 14-bit products. Then:
    - shift `closed` into a WIN_FRAMES-bit history;
    - perclos_cnt <= perclos_cnt + closed - oldest_bit;
    - if eye1_high > eye_ref, eye_ref <= eye_ref + 1 (slow upward adaptation; never decreases in RUN).
- Window fill: the history starts at all zeros, so perclos_cnt is valid from the first RUN frame and never exceeds WIN_FRAMES. No saturation logic is needed; the verifier must check the invariant perclos_cnt == popcount(history).
- Alarm: in RUN, on a valid tick, set when the updated count >= ALARM_CNT and clear when it <= CLEAR_CNT; otherwise hold. The alarm is only evaluated in RUN.
- recal (any state) clears eye_ref, cal_cnt, history, perclos_cnt, eye_closed and fatigue_alarm, and moves to CAL. If recal coincides with a tick, recal wins and that tick is not sampled.
- eye_ref = 0 in RUN (all calibration samples were zero height): every frame classifies as open.

## Timing
- Reset values: all outputs 0, state IDLE, history 0, m_d 0.
- Reset is asynchronous; asserting it mid-frame or mid-calibration returns the block to IDLE immediately.
- Cycle n: m first high. Cycle n+1: frame_tick high. Edge closing cycle n+1: sample taken. From cycle n+2: eye_closed, perclos_cnt, eye_ref, fatigue_alarm and cal_done show the updated values.
- All outputs are registered; no combinational path from any input to any output.
- Throughput: one sample per tick. Consecutive ticks must be at least 2 cycles apart, which the strobe guarantees.

## Test plan
- Reset, then 17 frames with eye1_high=40, eye1_Wide=30 -> first tick leaves IDLE; cal_done rises 2 cycles after the 17th m; eye_ref=40; perclos_cnt=0.
- After calibration, 30 frames with eye1_high=5 -> eye_closed=1; perclos_cnt counts 1..30; fatigue_alarm rises on the 26th frame.
- Continue with 64 frames of height 40 -> perclos_cnt falls from 30 starting when the first closed frame leaves the window; alarm holds at counts 17..25 and clears when the count reaches 16.
- m held high for 50 cycles per frame, plus frames with eye1_Wide=0 interleaved -> exactly one tick per frame; invalid frames leave perclos_cnt, the history and cal_cnt unchanged.
- recal pulsed in the same cycle as a RUN tick while the alarm is set -> alarm=0, perclos_cnt=0, eye_ref=0, cal_done=0; the next 16 valid frames recalibrate.
- module_rst_n asserted mid-window with perclos_cnt=20 -> all outputs 0 asynchronously; after release the sequence restarts from IDLE.

Source files
------------

// File: rtl/perclos_scheduler.sv
// Once per video frame, sample the eye height, calibrate an open-eye reference, and track
// closed frames over a sliding window with a hysteretic alarm. Sample lands 2 cycles after the strobe; there is no backpressure.
module perclos_scheduler #(
  parameter int WIN_FRAMES = 64,
  parameter int CAL_FRAMES = 16,
  parameter int ALARM_CNT  = 26,
  parameter int CLEAR_CNT  = 16
) (
  input  logic                                 module_clk,
  input  logic                                 module_rst_n,
  input  logic [10:0]                          lcd_pixel_xpos,
  input  logic [10:0]                          lcd_pixel_ypos,
  input  logic [10:0]                          eye1_high,
  input  logic [10:0]                          eye1_Wide,
  input  logic                                 recal,
  output logic                                 frame_tick,
  output logic                                 cal_done,
  output logic [10:0]                          eye_ref,
  output logic                                 eye_closed,
  output logic [$clog2(WIN_FRAMES+1)-1:0]      perclos_cnt,
  output logic                                 fatigue_alarm
);

  localparam int CW  = $clog2(WIN_FRAMES + 1);
  localparam int CCW = $clog2(CAL_FRAMES + 1);

  localparam logic [CW-1:0]  ALARM_TH = CW'(ALARM_CNT);
  localparam logic [CW-1:0]  CLEAR_TH = CW'(CLEAR_CNT);
  localparam logic [CCW-1:0] CAL_TH   = CCW'(CAL_FRAMES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAL  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  m_d_q, m_d_d;
  logic                  tick_q, tick_d;
  logic                  cal_done_q, cal_done_d;
  logic [10:0]           eye_ref_q, eye_ref_d;
  logic                  closed_q, closed_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  alarm_q, alarm_d;
  logic [CCW-1:0]        cal_cnt_q, cal_cnt_d;
  logic [WIN_FRAMES-1:0] hist_q, hist_d;

  logic        m;
  logic        valid;
  logic        closed_now;
  logic [13:0] high_x5;

  assign m       = (lcd_pixel_xpos == 11'd1) && (lcd_pixel_ypos == 11'd1);
  assign valid   = (eye1_Wide != 11'd0);
  // 14-bit product keeps 5*2047 exact; a zero reference can never classify closed.
  assign high_x5    = {3'b000, eye1_high} * 14'd5;
  assign closed_now = (high_x5 < {3'b000, eye_ref_q});

  always_comb begin
    m_d_d      = m;
    tick_d     = m & ~m_d_q;
    state_d    = state_q;
    eye_ref_d  = eye_ref_q;
    closed_d   = closed_q;
    cnt_d      = cnt_q;
    alarm_d    = alarm_q;
    cal_cnt_d  = cal_cnt_q;
    hist_d     = hist_q;

    if (recal) begin
      state_d   = ST_CAL;
      eye_ref_d = 11'd0;
      closed_d  = 1'b0;
      cnt_d     = '0;
      alarm_d   = 1'b0;
      cal_cnt_d = '0;
      hist_d    = '0;
    end else if (tick_q) begin
      case (state_q)
        ST_IDLE: state_d = ST_CAL;
        ST_CAL: begin
          if (valid) begin
            if (eye1_high > eye_ref_q) eye_ref_d = eye1_high;
            cal_cnt_d = cal_cnt_q + CCW'(1);
            if (cal_cnt_d == CAL_TH) state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (valid) begin
            closed_d = closed_now;
            hist_d   = {hist_q[WIN_FRAMES-2:0], closed_now};
            // Count tracks popcount of the history: add the newcomer, drop the evicted bit.
            cnt_d    = cnt_q + CW'(closed_now) - CW'(hist_q[WIN_FRAMES-1]);
            if (eye1_high > eye_ref_q) eye_ref_d = eye_ref_q + 11'd1;
            if (cnt_d >= ALARM_TH) begin
              alarm_d = 1'b1;
            end else if (cnt_d <= CLEAR_TH) begin
              alarm_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    cal_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      state_q    <= ST_IDLE;
      m_d_q      <= 1'b0;
      tick_q     <= 1'b0;
      cal_done_q <= 1'b0;
      eye_ref_q  <= 11'd0;
      closed_q   <= 1'b0;
      cnt_q      <= '0;
      alarm_q    <= 1'b0;
      cal_cnt_q  <= '0;
      hist_q     <= '0;
    end else begin
      state_q    <= state_d;
      m_d_q      <= m_d_d;
      tick_q     <= tick_d;
      cal_done_q <= cal_done_d;
      eye_ref_q  <= eye_ref_d;
      closed_q   <= closed_d;
      cnt_q      <= cnt_d;
      alarm_q    <= alarm_d;
      cal_cnt_q  <= cal_cnt_d;
      hist_q     <= hist_d;
    end
  end

  assign frame_tick    = tick_q;
  assign cal_done      = cal_done_q;
  assign eye_ref       = eye_ref_q;
  assign eye_closed    = closed_q;
  assign perclos_cnt   = cnt_q;
  assign fatigue_alarm = alarm_q;

endmodule

// File: tb/tb_perclos_scheduler.sv
// Bench for perclos_scheduler: frame-level reference model with directed and randomized frames.
module tb_perclos_scheduler;

  localparam int WIN = 64;

  logic        module_clk = 1'b0;
  logic        module_rst_n = 1'b1;
  logic [10:0] lcd_pixel_xpos = '0;
  logic [10:0] lcd_pixel_ypos = '0;
  logic [10:0] eye1_high = '0;
  logic [10:0] eye1_Wide = '0;
  logic        recal = 1'b0;
  logic        frame_tick;
  logic        cal_done;
  logic [10:0] eye_ref;
  logic        eye_closed;
  logic [6:0]  perclos_cnt;
  logic        fatigue_alarm;

  perclos_scheduler dut (
    .module_clk     (module_clk),
    .module_rst_n   (module_rst_n),
    .lcd_pixel_xpos (lcd_pixel_xpos),
    .lcd_pixel_ypos (lcd_pixel_ypos),
    .eye1_high      (eye1_high),
    .eye1_Wide      (eye1_Wide),
    .recal          (recal),
    .frame_tick     (frame_tick),
    .cal_done       (cal_done),
    .eye_ref        (eye_ref),
    .eye_closed     (eye_closed),
    .perclos_cnt    (perclos_cnt),
    .fatigue_alarm  (fatigue_alarm)
  );

  always #5 module_clk = ~module_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (frame %0d): got %0d, expected %0d", tag, frame_no, obs, exp);
    end
  endtask

  // Reference model: 0=idle 1=calibrating 2=running; window kept as a queue, newest first.
  int m_st, m_ref, m_cal, m_closed, m_alarm;
  bit m_hist[$];

  function automatic int m_count();
    int s = 0;
    foreach (m_hist[i]) s += int'(m_hist[i]);
    return s;
  endfunction

  task automatic m_clear();
    m_ref = 0; m_cal = 0; m_closed = 0; m_alarm = 0;
    m_hist.delete();
    for (int i = 0; i < WIN; i++) m_hist.push_back(1'b0);
  endtask

  task automatic m_frame(input int h, input int w, input bit rc);
    int c;
    int n;
    if (rc) begin
      m_clear();
      m_st = 1;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (w != 0) begin
      if (m_st == 1) begin
        if (h > m_ref) m_ref = h;
        m_cal++;
        if (m_cal == 16) m_st = 2;
      end else begin
        c = (h * 5 < m_ref) ? 1 : 0;
        m_closed = c;
        m_hist.push_front(c[0]);
        void'(m_hist.pop_back());
        n = m_count();
        if (n >= 26) m_alarm = 1;
        else if (n <= 16) m_alarm = 0;
        if (h > m_ref) m_ref++;
      end
    end
  endtask

  task automatic check_outs();
    chk("cal_done", 32'(cal_done), 32'(m_st == 2));
    chk("eye_ref", 32'(eye_ref), 32'(m_ref));
    chk("eye_closed", 32'(eye_closed), 32'(m_closed));
    chk("perclos_cnt", 32'(perclos_cnt), 32'(m_count()));
    chk("fatigue_alarm", 32'(fatigue_alarm), 32'(m_alarm));
  endtask

  // Strobe held for 'hold' cycles, then 4 idle cycles; recal lands in the tick cycle when rc is set.
  task automatic run_frame(input int h, input int w, input int hold, input bit rc);
    int ticks = 0;
    eye1_high = 11'(h);
    eye1_Wide = 11'(w);
    for (int i = 0; i < hold + 4; i++) begin
      @(negedge module_clk);
      if (frame_tick) ticks++;
      lcd_pixel_xpos = (i < hold) ? 11'd1 : 11'd0;
      lcd_pixel_ypos = (i < hold) ? 11'd1 : 11'd0;
      recal = rc && (i == 1);
    end
    frame_no++;
    m_frame(h, w, rc);
    chk("frame_tick_count", 32'(ticks), 32'd1);
    check_outs();
  endtask

  task automatic check_all_zero();
    chk("rst_frame_tick", 32'(frame_tick), 32'd0);
    chk("rst_cal_done", 32'(cal_done), 32'd0);
    chk("rst_eye_ref", 32'(eye_ref), 32'd0);
    chk("rst_eye_closed", 32'(eye_closed), 32'd0);
    chk("rst_perclos_cnt", 32'(perclos_cnt), 32'd0);
    chk("rst_fatigue_alarm", 32'(fatigue_alarm), 32'd0);
  endtask

  task automatic random_frames(input int n);
    int h, w;
    for (int k = 0; k < n; k++) begin
      h = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(30, 46);
      w = ($urandom_range(0, 3) == 0) ? 0 : 30;
      run_frame(h, w, $urandom_range(1, 50), 1'b0);
    end
  endtask

  initial begin
    m_st = 0;
    m_clear();
    #1 module_rst_n = 1'b0;
    #1 check_all_zero();
    repeat (3) @(negedge module_clk);
    module_rst_n = 1'b1;

    // Calibration: one tick to leave idle plus 16 valid samples.
    for (int k = 0; k < 17; k++) run_frame(40, 30, 1, 1'b0);
    // Closed run: count climbs, alarm sets at 26.
    for (int k = 0; k < 30; k++) run_frame(5, 30, 1, 1'b0);
    // Open run: closed frames age out, alarm clears at 16.
    for (int k = 0; k < 64; k++) run_frame(40, 30, 1, 1'b0);

    // Long strobes interleaved with invalid frames.
    for (int k = 0; k < 12; k++) run_frame((k % 2 == 0) ? 3 : 41, (k % 3 == 0) ? 0 : 30, 50, 1'b0);
    random_frames(60);

    // Alarm set, then recal coincident with a running tick.
    for (int k = 0; k < 30; k++) run_frame(2, 30, 1, 1'b0);
    run_frame(5, 30, 3, 1'b1);
    for (int k = 0; k < 16; k++) run_frame(0, 30, 2, 1'b0);
    // Zero reference: every frame classifies open.
    for (int k = 0; k < 4; k++) run_frame(0, 30, 1, 1'b0);
    run_frame(40, 30, 1, 1'b1);
    for (int k = 0; k < 16; k++) run_frame(40, 30, 1, 1'b0);
    for (int k = 0; k < 20; k++) run_frame(5, 30, 1, 1'b0);

    // Asynchronous reset in the middle of a frame.
    @(negedge module_clk);
    lcd_pixel_xpos = 11'd1;
    lcd_pixel_ypos = 11'd1;
    #2 module_rst_n = 1'b0;
    #1 check_all_zero();
    m_st = 0;
    m_clear();
    @(negedge module_clk);
    lcd_pixel_xpos = 11'd0;
    lcd_pixel_ypos = 11'd0;
    repeat (2) @(negedge module_clk);
    module_rst_n = 1'b1;
    for (int k = 0; k < 17; k++) run_frame(40, 30, 1, 1'b0);
    random_frames(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
